// File: rtl/tmds_decoder.sv
// TMDS receive symbol decoder: finds 10-bit word alignment from repeated control
// tokens, then decodes data and control symbols at the locked bit offset.
module tmds_decoder #(
   parameter int LOCK_COUNT = 8,
   parameter int TIMEOUT    = 1023
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic [9:0] i_tmds,
   output logic [7:0] o_data,
   output logic [1:0] o_control,
   output logic       o_de,
   output logic       o_locked,
   output logic       o_err
);
   localparam int LC_W = $clog2(LOCK_COUNT + 1);
   localparam int TO_W = $clog2(TIMEOUT + 1);

   typedef enum logic {SEARCH, LOCKED} state_t;
   state_t state, state_nxt;

   logic [9:0]      prev;
   logic [19:0]     cat;
   logic [9:0]      win [10];
   logic [9:0]      hit;
   logic            any_hit;
   logic [3:0]      cand, cand_r, cand_nxt, off, off_nxt;
   logic [LC_W-1:0] mcnt, mcnt_nxt;
   logic [TO_W-1:0] tcnt, tcnt_nxt;
   logic [9:0]      q;
   logic            q_tok;
   logic [7:0]      d, q_data;
   logic [7:0]      data_nxt;
   logic [1:0]      ctl_nxt;
   logic            de_nxt, lock_nxt, err_nxt;

   function automatic logic is_tok(input logic [9:0] w);
      return (w == 10'b1101010100) || (w == 10'b0010101011) ||
             (w == 10'b0101010100) || (w == 10'b1010101011);
   endfunction

   function automatic logic [1:0] tok_code(input logic [9:0] w);
      case (w)
         10'b0010101011: return 2'b01;
         10'b0101010100: return 2'b10;
         10'b1010101011: return 2'b11;
         default:        return 2'b00;
      endcase
   endfunction

   // Older word sits in the low half so offset k starts at the k-th oldest bit.
   assign cat = {i_tmds, prev};

   for (genvar k = 0; k < 10; k++) begin : g_win
      assign win[k] = cat[k+9:k];
      assign hit[k] = is_tok(win[k]);
   end

   assign any_hit = |hit;

   always_comb begin
      cand = 4'd0;
      for (int k = 9; k >= 0; k--)
         if (hit[k]) cand = 4'(k);
   end

   assign q     = win[off];
   assign q_tok = is_tok(q);
   assign d     = q[9] ? ~q[7:0] : q[7:0];

   always_comb begin
      q_data    = '0;
      q_data[0] = d[0];
      for (int i = 1; i < 8; i++)
         q_data[i] = q[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
   end

   always_comb begin
      state_nxt = state;
      cand_nxt  = cand_r;
      off_nxt   = off;
      mcnt_nxt  = mcnt;
      tcnt_nxt  = tcnt;
      data_nxt  = '0;
      ctl_nxt   = o_control;
      de_nxt    = 1'b0;
      lock_nxt  = 1'b0;
      err_nxt   = 1'b0;
      case (state)
         SEARCH: begin
            ctl_nxt = 2'b00;
            if (!any_hit)
               mcnt_nxt = '0;
            else if (cand == cand_r)
               mcnt_nxt = mcnt + 1'b1;
            else begin
               cand_nxt = cand;
               mcnt_nxt = LC_W'(1);
            end
            // The word that completes lock is only counted, never decoded.
            if (any_hit && mcnt_nxt == LC_W'(LOCK_COUNT)) begin
               state_nxt = LOCKED;
               off_nxt   = cand_nxt;
               mcnt_nxt  = '0;
               lock_nxt  = 1'b1;
            end
         end
         LOCKED: begin
            lock_nxt = 1'b1;
            if (q_tok) begin
               tcnt_nxt = '0;
               ctl_nxt  = tok_code(q);
            end else if (tcnt == TO_W'(TIMEOUT - 1)) begin
               state_nxt = SEARCH;
               tcnt_nxt  = '0;
               mcnt_nxt  = '0;
               cand_nxt  = '0;
               off_nxt   = '0;
               ctl_nxt   = 2'b00;
               lock_nxt  = 1'b0;
               err_nxt   = 1'b1;
            end else begin
               tcnt_nxt = tcnt + 1'b1;
               de_nxt   = 1'b1;
               data_nxt = q_data;
            end
         end
         default: state_nxt = SEARCH;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state     <= SEARCH;
         prev      <= '0;
         cand_r    <= '0;
         off       <= '0;
         mcnt      <= '0;
         tcnt      <= '0;
         o_data    <= '0;
         o_control <= '0;
         o_de      <= 1'b0;
         o_locked  <= 1'b0;
         o_err     <= 1'b0;
      end else begin
         state     <= state_nxt;
         prev      <= i_tmds;
         cand_r    <= cand_nxt;
         off       <= off_nxt;
         mcnt      <= mcnt_nxt;
         tcnt      <= tcnt_nxt;
         o_data    <= data_nxt;
         o_control <= ctl_nxt;
         o_de      <= de_nxt;
         o_locked  <= lock_nxt;
         o_err     <= err_nxt;
      end
   end

endmodule
